// File: rtl/mandelbrot_iterator.sv
// Mandelbrot escape-time engine: one point in flight, (k+1)*(MUL_LAT+1) cycles from accept to out_valid.
// Backpressure: in_ready only in IDLE; the result holds in DONE until out_valid && out_ready.

// Pipelined signed multiplier, full-width product, MUL_LAT cycles, free-running (no stall).
module mandelbrot_mul #(
   parameter int WIDTH = 32,
   parameter int LAT   = 2
) (
   input  logic                      clk,
   input  logic signed [WIDTH-1:0]   a,
   input  logic signed [WIDTH-1:0]   b,
   output logic signed [2*WIDTH-1:0] p
);
   typedef logic signed [2*WIDTH-1:0] prod_t;

   prod_t pipe [LAT];

   always_ff @(posedge clk) begin
      pipe[0] <= prod_t'(a) * prod_t'(b);
      for (int i = 1; i < LAT; i++) begin
         pipe[i] <= pipe[i-1];
      end
   end

   assign p = pipe[LAT-1];
endmodule

module mandelbrot_iterator #(
   parameter int WIDTH   = 32,
   parameter int FRAC    = 28,
   parameter int ITER_W  = 16,
   parameter int MUL_LAT = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [WIDTH-1:0]  c_re,
   input  logic signed [WIDTH-1:0]  c_im,
   input  logic [ITER_W-1:0]        max_iter,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ITER_W-1:0]        out_iter,
   output logic                     out_escaped
);
   localparam int PW = 2 * WIDTH;
   localparam int AW = PW - FRAC;
   localparam int MW = AW + 1;
   localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic signed [MW-1:0] ESC_LIM = MW'(4) <<< FRAC;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_EVAL, S_DONE} state_t;

   typedef struct packed {
      logic signed [WIDTH-1:0] re;
      logic signed [WIDTH-1:0] im;
      logic [ITER_W-1:0]       max_iter;
   } point_t;

   state_t                  state;
   point_t                  pt;
   logic signed [WIDTH-1:0] z_re;
   logic signed [WIDTH-1:0] z_im;
   logic [ITER_W-1:0]       k;
   logic [CW-1:0]           mul_cnt;

   logic signed [PW-1:0]    p_aa;
   logic signed [PW-1:0]    p_bb;
   logic signed [PW-1:0]    p_ab;
   logic signed [AW-1:0]    aa;
   logic signed [AW-1:0]    bb;
   logic signed [AW-1:0]    ab;
   logic signed [MW-1:0]    mag;
   logic                    escape_hit;
   logic                    limit_hit;

   // z is held constant for the whole MUL phase, so the pipeline output
   // seen in EVAL always belongs to the current iteration.
   mandelbrot_mul #(.WIDTH(WIDTH), .LAT(MUL_LAT)) u_mul_aa (.clk(clk), .a(z_re), .b(z_re), .p(p_aa));
   mandelbrot_mul #(.WIDTH(WIDTH), .LAT(MUL_LAT)) u_mul_bb (.clk(clk), .a(z_im), .b(z_im), .p(p_bb));
   mandelbrot_mul #(.WIDTH(WIDTH), .LAT(MUL_LAT)) u_mul_ab (.clk(clk), .a(z_re), .b(z_im), .p(p_ab));

   assign aa         = AW'(p_aa >>> FRAC);
   assign bb         = AW'(p_bb >>> FRAC);
   assign ab         = AW'(p_ab >>> FRAC);
   assign mag        = MW'(aa) + MW'(bb);
   assign escape_hit = (mag > ESC_LIM);
   assign limit_hit  = (k == pt.max_iter);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         out_iter    <= '0;
         out_escaped <= 1'b0;
         pt          <= '0;
         z_re        <= '0;
         z_im        <= '0;
         k           <= '0;
         mul_cnt     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  pt.re       <= c_re;
                  pt.im       <= c_im;
                  pt.max_iter <= max_iter;
                  z_re        <= '0;
                  z_im        <= '0;
                  k           <= '0;
                  mul_cnt     <= '0;
                  in_ready    <= 1'b0;
                  state       <= S_MUL;
               end
            end
            S_MUL: begin
               if (mul_cnt == CW'(MUL_LAT - 1)) begin
                  mul_cnt <= '0;
                  state   <= S_EVAL;
               end else begin
                  mul_cnt <= mul_cnt + 1'b1;
               end
            end
            S_EVAL: begin
               // Escape wins over the limit when both hold in the same pass.
               if (escape_hit) begin
                  out_iter    <= k;
                  out_escaped <= 1'b1;
                  out_valid   <= 1'b1;
                  state       <= S_DONE;
               end else if (limit_hit) begin
                  out_iter    <= pt.max_iter;
                  out_escaped <= 1'b0;
                  out_valid   <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  z_re  <= WIDTH'(aa - bb) + pt.re;
                  z_im  <= WIDTH'(ab <<< 1) + pt.im;
                  k     <= k + 1'b1;
                  state <= S_MUL;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mandelbrot_iterator.sv
// Directed bench for mandelbrot_iterator: expected results queued at accept, checked at out_valid.
module tb_mandelbrot_iterator;
   localparam int WIDTH    = 32;
   localparam int FRAC     = 28;
   localparam int ITER_W   = 16;
   localparam int MUL_LAT  = 2;
   localparam int ITER_CYC = MUL_LAT + 1;

   localparam logic signed [WIDTH-1:0] ONE  = 32'sh1000_0000;
   localparam logic signed [WIDTH-1:0] TWO  = 32'sh2000_0000;
   localparam logic signed [WIDTH-1:0] NTWO = -32'sh2000_0000;
   localparam logic signed [WIDTH-1:0] HALF = 32'sh0800_0000;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] c_re;
   logic signed [WIDTH-1:0] c_im;
   logic [ITER_W-1:0]       max_iter;
   logic                    out_valid;
   logic                    out_ready;
   logic [ITER_W-1:0]       out_iter;
   logic                    out_escaped;

   typedef struct {
      int   iter;
      logic esc;
      int   lat;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   acc_cyc = 0;

   mandelbrot_iterator #(
      .WIDTH(WIDTH), .FRAC(FRAC), .ITER_W(ITER_W), .MUL_LAT(MUL_LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .c_re(c_re), .c_im(c_im), .max_iter(max_iter),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_iter(out_iter), .out_escaped(out_escaped)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Presents one point and queues its expected result; returns at the negedge after accept.
   task automatic send(input logic signed [WIDTH-1:0] re, input logic signed [WIDTH-1:0] im,
                       input int mi, input int eiter, input logic eesc);
      int   n = 0;
      exp_t e;
      @(negedge clk);
      while (!in_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("send_in_ready", in_ready, 1);
      c_re     = re;
      c_im     = im;
      max_iter = mi[ITER_W-1:0];
      in_valid = 1'b1;
      acc_cyc  = cyc;
      e.iter   = eiter;
      e.esc    = eesc;
      e.lat    = (eiter + 1) * ITER_CYC + 1;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      c_re     = $urandom;
      c_im     = $urandom;
      max_iter = ITER_W'($urandom);
   endtask

   // Waits for a result, compares it, optionally stalls 'hold' cycles, then completes the handshake.
   task automatic recv(input int hold);
      int                n = 0;
      exp_t              e;
      logic [ITER_W-1:0] it;
      logic              es;
      while (!out_valid && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("out_valid_seen", out_valid, 1);
      check("sb_depth", sb.size(), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("latency", cyc - acc_cyc, e.lat);
         check("out_iter", out_iter, e.iter);
         check("out_escaped", out_escaped, e.esc);
      end
      check("busy_in_ready", in_ready, 0);
      it = out_iter;
      es = out_escaped;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         c_re     = ONE;
         c_im     = 0;
         max_iter = 3;
         @(negedge clk);
         check("bp_out_valid", out_valid, 1);
         check("bp_out_iter", out_iter, it);
         check("bp_out_escaped", out_escaped, es);
         check("bp_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("post_out_valid", out_valid, 0);
      check("post_in_ready", in_ready, 1);
   endtask

   initial begin
      int seen;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      c_re      = 0;
      c_im      = 0;
      max_iter  = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_iter", out_iter, 0);
      check("rst_out_escaped", out_escaped, 0);

      send(0, 0, 10, 10, 1'b0);       recv(0);
      send(ONE, 0, 50, 3, 1'b1);      recv(0);
      send(NTWO, 0, 20, 20, 1'b0);    recv(0);
      send(0, ONE, 8, 8, 1'b0);       recv(0);
      send(TWO, 0, 0, 0, 1'b0);       recv(0);
      send(TWO, 0, 5, 2, 1'b1);       recv(7);

      // The point offered during the stall must not have been taken.
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("ignored_point_no_output", seen, 0);

      // 0.5+0.5i: orbit 0.5+0.5i, 0.5+i, -0.25+1.5i, -1.6875-0.25i, 3.28515625+1.34375i
      send(HALF, HALF, 50, 5, 1'b1);  recv(0);

      // Reset during the MUL phase of iteration 3 drops the point.
      send(0, 0, 10, 10, 1'b0);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out_valid", out_valid, 0);
      sb.delete();
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("midrst_no_output", seen, 0);

      send(ONE, 0, 50, 3, 1'b1);      recv(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end
endmodule
